// File: rtl/parity_frame_rx.sv
// parity_frame_rx: serial frame receiver (LSB first, parity bit last) with valid/ready output and saturating error count.
// Define PARITY_RX_ODD_EN to check odd parity instead of even.
module parity_frame_rx #(
    parameter int size      = 32,
    parameter int cnt_width = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 in_ready,
    output logic [size-1:0]      out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 parity_err,
    output logic [cnt_width-1:0] err_count
);
    localparam int CW = $clog2(size);
    localparam logic [CW-1:0] LAST = CW'(size - 1);
    typedef enum logic [1:0] {IDLE, DATA, PARITY, HOLD} state_t;
    state_t                r_state, w_next;
    logic [size-1:0]       r_shift, r_out;
    logic [CW-1:0]         r_cnt;
    logic                  r_acc, r_valid, r_err, w_perr;
    logic [cnt_width-1:0]  r_err_count;
`ifdef PARITY_RX_ODD_EN
    assign w_perr = ~(r_acc ^ bit_in);
`else
    assign w_perr = r_acc ^ bit_in;
`endif
    assign in_ready   = (r_state != HOLD);
    assign out        = r_out;
    assign out_valid  = r_valid;
    assign parity_err = r_err;
    assign err_count  = r_err_count;
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (frame_start) w_next = DATA;
            DATA:    if (bit_valid && r_cnt == LAST) w_next = PARITY;
            PARITY:  if (bit_valid) w_next = HOLD;
            default: if (out_ready) w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_out       <= '0;
            r_cnt       <= '0;
            r_acc       <= 1'b0;
            r_valid     <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (frame_start) begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_acc   <= 1'b0;
                end
                DATA: if (bit_valid) begin
                    r_shift[r_cnt] <= bit_in;
                    r_acc          <= r_acc ^ bit_in;
                    r_cnt          <= r_cnt + 1'b1;
                end
                PARITY: if (bit_valid) begin
                    r_out   <= r_shift;
                    r_err   <= w_perr;
                    r_valid <= 1'b1;
                    // saturate rather than wrap so a flood of bad frames stays visible
                    if (w_perr && r_err_count != {cnt_width{1'b1}}) r_err_count <= r_err_count + 1'b1;
                end
                default: if (out_ready) begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: randomized frames against a ones-count parity model; second instance checks counter saturation.
module tb_parity_frame_rx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid, parity_err, s_in_ready, s_out_valid, s_parity_err;
    logic [31:0] out, s_out;
    logic [7:0]  err_count;
    logic [1:0]  s_err_count;
    int          n_pass = 0, n_chk = 0;
    int          ec = 0, ec2 = 0;

    always #5 clk = ~clk;

    parity_frame_rx #(.size(32), .cnt_width(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_in(bit_in), .bit_valid(bit_valid),
        .in_ready(in_ready), .out(out), .out_valid(out_valid), .out_ready(out_ready),
        .parity_err(parity_err), .err_count(err_count));

    parity_frame_rx #(.size(32), .cnt_width(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .bit_in(bit_in), .bit_valid(bit_valid),
        .in_ready(s_in_ready), .out(s_out), .out_valid(s_out_valid), .out_ready(out_ready),
        .parity_err(s_parity_err), .err_count(s_err_count));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_err(input logic [31:0] w, input logic p);
        int ones = $countones(w) + int'(p);
`ifdef PARITY_RX_ODD_EN
        return (ones % 2) == 0;
`else
        return (ones % 2) == 1;
`endif
    endfunction

    function automatic logic bad_p(input logic [31:0] w);
        return exp_err(w, 1'b0) ? 1'b0 : 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input int maxgap);
        int g = (maxgap == 0) ? 0 : int'($urandom_range(maxgap));
        for (int k = 0; k < g; k++) begin
            bit_valid   = 1'b0;
            bit_in      = 1'($urandom);
            frame_start = 1'($urandom);
            tick();
        end
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] w, input logic p, input int maxgap);
        logic e;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            gap(maxgap);
            bit_valid = 1'b1;
            bit_in    = w[i];
            tick();
            bit_valid = 1'b0;
        end
        gap(maxgap);
        bit_valid = 1'b1;
        bit_in    = p;
        tick();
        bit_valid = 1'b0;
        e   = exp_err(w, p);
        ec  = (e && ec < 255) ? ec + 1 : ec;
        ec2 = (e && ec2 < 3) ? ec2 + 1 : ec2;
        check("out_valid", 64'(out_valid), 64'(1));
        check("out", 64'(out), 64'(w));
        check("parity_err", 64'(parity_err), 64'(e));
        check("err_count", 64'(err_count), 64'(ec));
        check("sat_err_count", 64'(s_err_count), 64'(ec2));
        check("in_ready_hold", 64'(in_ready), 64'(0));
    endtask

    task automatic accept(input logic [31:0] w, input int hold, input logic fs_acc);
        logic e = parity_err;
        for (int k = 0; k < hold; k++) begin
            out_ready   = 1'b0;
            bit_valid   = 1'($urandom);
            bit_in      = 1'($urandom);
            frame_start = 1'($urandom);
            tick();
            check("hold_out", 64'(out), 64'(w));
            check("hold_err", 64'(parity_err), 64'(e));
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        bit_valid   = 1'b0;
        frame_start = fs_acc;
        out_ready   = 1'b1;
        tick();
        out_ready   = 1'b0;
        frame_start = 1'b0;
        check("acc_valid", 64'(out_valid), 64'(0));
        check("acc_err", 64'(parity_err), 64'(0));
        check("acc_in_ready", 64'(in_ready), 64'(1));
        check("acc_out_kept", 64'(out), 64'(w));
        bit_valid = 1'b1;
        bit_in    = 1'($urandom);
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic frame(input logic [31:0] w, input logic p, input int maxgap, input int hold, input logic fs_acc);
        send_frame(w, p, maxgap);
        accept(w, hold, fs_acc);
    endtask

    initial begin
        logic [31:0] w;
        #2;
        check("rst_out", 64'(out), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_err", 64'(parity_err), 64'(0));
        check("rst_count", 64'(err_count), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        frame(32'h0F75_706A, 1'b0, 0, 5, 1'b0);
        frame(32'hFFFF_FFFF, 1'b1, 0, 1, 1'b1);
        frame(32'h7FFF_FFFF, 1'b1, 0, 0, 1'b0);
        frame(32'h0F75_706A, 1'b0, 3, 2, 1'b1);
        for (int n = 0; n < 8; n++) begin
            w = $urandom;
            frame(w, 1'($urandom), int'($urandom_range(3)), int'($urandom_range(3)), 1'($urandom));
        end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'($urandom);
            tick();
        end
        bit_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'(0));
        check("midrst_count", 64'(err_count), 64'(0));
        check("midrst_sat_count", 64'(s_err_count), 64'(0));
        check("midrst_out", 64'(out), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        ec  = 0;
        ec2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        frame(32'h0000_0000, 1'b0, 1, 1, 1'b0);
        frame(32'h0000_0000, 1'b1, 1, 1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ec  = 0;
        ec2 = 0;
        tick();
        for (int n = 1; n <= 5; n++) begin
            w = $urandom;
            send_frame(w, bad_p(w), 1);
            check("sat_seq", 64'(s_err_count), 64'((n < 3) ? n : 3));
            accept(w, 0, 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
